instr_control_fsm: RTL

- Multi-cycle fetch/decode/execute controller sitting directly upstream of the data path.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Decodes each instruction into the data path's control inputs: ALU opcode, register selects, immediate and immediate select, and the one-hot register-bank write enable.
- Owns the program counter.

---
 rtl/cpu_pkg.sv | 54 +++++
 rtl/instr_decode.sv | 57 +++++
 rtl/instr_control_fsm.sv | 88 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction control FSM and its decoder.
// Holds the state encoding, opcode/ext constants, field positions and the decode bundle.
package cpu_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  // Major opcodes in IR[15:12]; 4'h4, 4'h8 and 4'hC are unassigned and decode as NOP.
  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ANDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_XORI  = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_ADDUI = 4'h6;
  localparam logic [3:0] OP_ADDCI = 4'h7;
  localparam logic [3:0] OP_SUBI  = 4'h9;
  localparam logic [3:0] OP_SUBCI = 4'hA;
  localparam logic [3:0] OP_CMPI  = 4'hB;
  localparam logic [3:0] OP_MOVI  = 4'hD;
  localparam logic [3:0] OP_MULI  = 4'hE;
  localparam logic [3:0] OP_LUI   = 4'hF;

  // R-type compare only sets flags, so it is the one R-type op without writeback.
  localparam logic [3:0] EXT_CMP = 4'hB;

  localparam int OP_MSB   = 15;
  localparam int OP_LSB   = 12;
  localparam int RD_MSB   = 11;
  localparam int RD_LSB   = 8;
  localparam int EXT_MSB  = 7;
  localparam int EXT_LSB  = 4;
  localparam int RS_MSB   = 3;
  localparam int RS_LSB   = 0;
  localparam int IMM8_MSB = 7;
  localparam int IMM8_LSB = 0;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [15:0] imm;
    logic        imm_sel;
    logic        writes_back;
  } decode_t;

  function automatic logic [15:0] sign_ext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: maps the 16-bit IR to the data path control bundle.
// Unsupported major opcodes produce an all-zero bundle, which the FSM treats as a NOP.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] ir,
  output decode_t     dec
);

  logic [3:0] major;
  logic [3:0] ext;
  logic [3:0] rd;
  logic [3:0] rs;
  logic [7:0] imm8;

  assign major = ir[OP_MSB:OP_LSB];
  assign ext   = ir[EXT_MSB:EXT_LSB];
  assign rd    = ir[RD_MSB:RD_LSB];
  assign rs    = ir[RS_MSB:RS_LSB];
  assign imm8  = ir[IMM8_MSB:IMM8_LSB];

  always_comb begin
    // NOTE: default every output first so no path through the case leaves one unassigned (no latch).
    dec = '0;
    case (major)
      OP_RTYPE: begin
        dec.opcode      = {4'h0, ext};
        dec.rdest       = rd;
        dec.rsrc        = rs;
        dec.writes_back = (ext != EXT_CMP);
      end
      OP_ADDI, OP_ADDUI, OP_ADDCI, OP_SUBI, OP_SUBCI, OP_CMPI, OP_MULI: begin
        dec.opcode      = {major, 4'h0};
        dec.rdest       = rd;
        dec.imm         = sign_ext8(imm8);
        dec.imm_sel     = 1'b1;
        dec.writes_back = (major != OP_CMPI);
      end
      OP_ANDI, OP_ORI, OP_XORI, OP_MOVI: begin
        dec.opcode      = {major, 4'h0};
        dec.rdest       = rd;
        dec.imm         = {8'h00, imm8};
        dec.imm_sel     = 1'b1;
        dec.writes_back = 1'b1;
      end
      OP_LUI: begin
        dec.opcode      = {major, 4'h0};
        dec.rdest       = rd;
        dec.imm         = {imm8, 8'h00};
        dec.imm_sel     = 1'b1;
        dec.writes_back = 1'b1;
      end
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/instr_control_fsm.sv
// Fetch/decode/execute controller: fetches over req/ack, registers decoded controls,
// strobes the one-hot register write in EXECUTE and owns the program counter.
module instr_control_fsm
  import cpu_pkg::*;
#(
  parameter int                   PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0,
  parameter int                   NUM_REGS = 16
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic [15:0]         imem_data,
  output logic [7:0]          opcode,
  output logic [3:0]          Rdest_select,
  output logic [3:0]          Rsrc_select,
  output logic [15:0]         Imm,
  output logic                Imm_select,
  output logic [NUM_REGS-1:0] wEnable,
  output logic [PC_WIDTH-1:0] pc,
  output logic [1:0]          state_dbg
);

  state_t      state;
  logic [15:0] ir;
  decode_t     dec;

  instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  assign imem_addr = pc;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state        <= FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      imem_req     <= 1'b0;
      opcode       <= '0;
      Rdest_select <= '0;
      Rsrc_select  <= '0;
      Imm          <= '0;
      Imm_select   <= 1'b0;
      wEnable      <= '0;
    end else begin
      case (state)
        FETCH: begin
          // The first FETCH cycle after reset only raises req; an ack there is ignored.
          if (imem_req && imem_ack) begin
            ir       <= imem_data;
            imem_req <= 1'b0;
            state    <= DECODE;
          end else begin
            imem_req <= 1'b1;
          end
        end
        DECODE: begin
          opcode       <= dec.opcode;
          Rdest_select <= dec.rdest;
          Rsrc_select  <= dec.rsrc;
          Imm          <= dec.imm;
          Imm_select   <= dec.imm_sel;
          // Registered here so the strobe is visible for exactly the EXECUTE cycle.
          wEnable      <= dec.writes_back ? (NUM_REGS'(1) << dec.rdest) : '0;
          state        <= EXECUTE;
        end
        EXECUTE: begin
          wEnable  <= '0;
          pc       <= pc + PC_WIDTH'(1);
          imem_req <= 1'b1;
          state    <= FETCH;
        end
        default: begin
          wEnable  <= '0;
          imem_req <= 1'b1;
          state    <= FETCH;
        end
      endcase
    end
  end

endmodule
